// File: rtl/touch_adc_pkg.sv
// Shared types and constants for the touch-ADC scheduler.
// Holds the FSM state encoding, the default X/Y command bytes and the ADC result width.
package touch_adc_pkg;

    localparam int ADC_W = 12;

    localparam logic [7:0] CMD_X_DEF = 8'h92;
    localparam logic [7:0] CMD_Y_DEF = 8'hD2;

    typedef enum logic [3:0] {
        IDLE,
        DEBOUNCE,
        CONV_X,
        WAIT_X,
        CONV_Y,
        WAIT_Y,
        ACCUM,
        REPORT,
        GAP,
        AUX_CONV,
        AUX_WAIT
    } adcStateT;

endpackage

// File: rtl/touch_pen_debounce.sv
// Pen-down synchronizer and debounce counter; penStable marks the last debounce cycle.
// Latency: 2 cycles through the synchronizer. No backpressure: the FSM owns clear and count enable.
module touch_pen_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iPENIRQ_n,
    input  logic iClear,
    input  logic iCount,
    output logic penDn,
    output logic penStable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to "pen up" so nothing is scanned straight out of reset.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= iPENIRQ_n;
            sync2 <= sync1;
            if (iClear)
                cnt <= '0;
            else if (iCount && penDn && !penStable)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign penDn     = !sync2;
    assign penStable = penDn && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/touch_adc_scheduler.sv
// Touch-ADC scheduler: debounced pen scan, averaged X/Y reports with IRQ, shared with one aux requester.
// Latency: outputs registered one cycle after the deciding state; ADC_TIMEOUT_EN adds a done watchdog.
// Backpressure: conversions wait on iCONV_DONE; aux is only admitted from IDLE or at the end of GAP.
module touch_adc_scheduler
    import touch_adc_pkg::*;
#(
    parameter int         DEBOUNCE_CYC = 20000,
    parameter int         GAP_CYC      = 50000,
    parameter int         AVG_LOG2     = 2,
    parameter logic [7:0] CMD_X        = CMD_X_DEF,
    parameter logic [7:0] CMD_Y        = CMD_Y_DEF,
    parameter int         TIMEOUT_CYC  = 4096
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iADC_PENIRQ_n,
    output logic             oCONV_START,
    output logic [7:0]       oCONV_CMD,
    input  logic             iCONV_DONE,
    input  logic [ADC_W-1:0] iCONV_DATA,
    input  logic             iAUX_REQ,
    input  logic [7:0]       iAUX_CMD,
    output logic             oAUX_VALID,
    output logic [ADC_W-1:0] oAUX_DATA,
    output logic [ADC_W-1:0] oX_COORD,
    output logic [ADC_W-1:0] oY_COORD,
    output logic             oCOORD_VALID,
    output logic             oTOUCH_IRQ,
    input  logic             iIRQ_ACK,
    output logic             oPEN_UP
`ifdef ADC_TIMEOUT_EN
    ,
    output logic             oTIMEOUT_ERR
`endif
);

    localparam int ACC_W  = ADC_W + AVG_LOG2;
    localparam int PAIR_W = AVG_LOG2 + 1;
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam logic [PAIR_W-1:0] PAIRS = PAIR_W'(1 << AVG_LOG2);

    if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || TIMEOUT_CYC < 1) begin : gBadParams
        $error("touch_adc_scheduler: AVG_LOG2 must be 0..4 and TIMEOUT_CYC positive");
    end

    adcStateT          state;
    logic [ACC_W-1:0]  accX;
    logic [ACC_W-1:0]  accY;
    logic [PAIR_W-1:0] pairCnt;
    logic [GAP_W-1:0]  gapCnt;
    logic              scanActive;
    logic              penDn;
    logic              penStable;

    touch_pen_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) uDebounce (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iPENIRQ_n (iADC_PENIRQ_n),
        .iClear    (state == IDLE),
        .iCount    (state == DEBOUNCE),
        .penDn     (penDn),
        .penStable (penStable)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdCnt;
    logic            inWait;
    assign inWait = (state == WAIT_X) || (state == WAIT_Y) || (state == AUX_WAIT);
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= IDLE;
            accX         <= '0;
            accY         <= '0;
            pairCnt      <= '0;
            gapCnt       <= '0;
            scanActive   <= 1'b0;
            oCONV_START  <= 1'b0;
            oCONV_CMD    <= 8'h00;
            oAUX_VALID   <= 1'b0;
            oAUX_DATA    <= '0;
            oX_COORD     <= '0;
            oY_COORD     <= '0;
            oCOORD_VALID <= 1'b0;
            oTOUCH_IRQ   <= 1'b0;
            oPEN_UP      <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            wdCnt        <= '0;
            oTIMEOUT_ERR <= 1'b0;
`endif
        end else begin
            oCONV_START  <= 1'b0;
            oAUX_VALID   <= 1'b0;
            oCOORD_VALID <= 1'b0;
            oPEN_UP      <= 1'b0;
            if (iIRQ_ACK)
                oTOUCH_IRQ <= 1'b0;

            case (state)
                // The cycle carrying oAUX_VALID still sees the old request, so it is not re-taken.
                IDLE: begin
                    if (iAUX_REQ && !oAUX_VALID) begin
                        scanActive <= 1'b0;
                        state      <= AUX_CONV;
                    end else if (penDn) begin
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!penDn)
                        state <= IDLE;
                    else if (penStable)
                        state <= CONV_X;
                end
                CONV_X: begin
                    oCONV_START <= 1'b1;
                    oCONV_CMD   <= CMD_X;
                    state       <= WAIT_X;
                end
                WAIT_X: begin
                    if (iCONV_DONE) begin
                        accX  <= accX + ACC_W'(iCONV_DATA);
                        state <= CONV_Y;
                    end
                end
                CONV_Y: begin
                    oCONV_START <= 1'b1;
                    oCONV_CMD   <= CMD_Y;
                    state       <= WAIT_Y;
                end
                WAIT_Y: begin
                    if (iCONV_DONE) begin
                        accY  <= accY + ACC_W'(iCONV_DATA);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    pairCnt <= pairCnt + PAIR_W'(1);
                    state   <= (pairCnt + PAIR_W'(1) == PAIRS) ? REPORT : CONV_X;
                end
                REPORT: begin
                    oX_COORD     <= ADC_W'(accX >> AVG_LOG2);
                    oY_COORD     <= ADC_W'(accY >> AVG_LOG2);
                    oCOORD_VALID <= 1'b1;
                    oTOUCH_IRQ   <= 1'b1;
                    accX         <= '0;
                    accY         <= '0;
                    pairCnt      <= '0;
                    gapCnt       <= '0;
                    state        <= GAP;
                end
                GAP: begin
                    if (!penDn) begin
                        oPEN_UP <= 1'b1;
                        state   <= IDLE;
                    end else if (gapCnt == GAP_W'(GAP_CYC - 1)) begin
                        if (iAUX_REQ) begin
                            scanActive <= 1'b1;
                            state      <= AUX_CONV;
                        end else begin
                            state <= CONV_X;
                        end
                    end else begin
                        gapCnt <= gapCnt + GAP_W'(1);
                    end
                end
                AUX_CONV: begin
                    oCONV_START <= 1'b1;
                    oCONV_CMD   <= iAUX_CMD;
                    state       <= AUX_WAIT;
                end
                AUX_WAIT: begin
                    if (iCONV_DONE) begin
                        oAUX_DATA  <= iCONV_DATA;
                        oAUX_VALID <= 1'b1;
                        scanActive <= 1'b0;
                        state      <= scanActive ? CONV_X : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef ADC_TIMEOUT_EN
            oTIMEOUT_ERR <= 1'b0;
            wdCnt        <= inWait ? wdCnt + WD_W'(1) : '0;
            // Abandon the whole scan; a still-raised aux request is picked up again from IDLE.
            if (inWait && !iCONV_DONE && wdCnt == WD_W'(TIMEOUT_CYC - 1)) begin
                accX         <= '0;
                accY         <= '0;
                pairCnt      <= '0;
                scanActive   <= 1'b0;
                wdCnt        <= '0;
                oTIMEOUT_ERR <= 1'b1;
                state        <= IDLE;
            end
`endif
        end
    end

endmodule
